// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Fetch-stage controller between the instruction buffer and decode.
//   - Generates the fetch PC (pc_out) and the constant buffer base (base_out).
//   - Tracks the single request in flight through the buffer's one-cycle
//     registered read, and pushes the returned word with its PC into a
//     2-entry queue.
//   - Presents the queue head to decode over a valid/ready handshake.
//   - A redirect flushes the queue, drops the in-flight request and reloads
//     the fetch PC.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   rst            : asynchronous active-high reset
//   pc_out         : fetch PC to the buffer (copy of the fetch PC register)
//   base_out       : buffer base, constant RESET_PC
//   ins_in         : buffer read data, valid the cycle after its PC was shown
//   redirect_valid : redirect request from execute
//   redirect_pc    : redirect target PC
//   dec_valid      : queue head valid
//   dec_ready      : decode accepts the head
//   dec_ins        : head instruction word
//   dec_pc         : PC of the head instruction
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    output logic [31:0] base_out,
    input  logic [31:0] ins_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_ins,
    output logic [31:0] dec_pc
);

    // Fetch state
    logic [31:0] pc_r;
    logic        inflight_r;
    logic [31:0] inflight_pc_r;

    // Two-entry queue of {pc, ins}
    logic [31:0] q_pc_r  [2];
    logic [31:0] q_ins_r [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;

    // Handshake / control decode
    logic        pop_s;
    logic        push_s;
    logic        issue_s;
    logic [2:0]  occ_s;

    // Pop, push and the credit-based issue decision.
    always_comb begin
        pop_s   = 1'b0;
        push_s  = 1'b0;
        issue_s = 1'b0;
        occ_s   = 3'd0;
        pop_s   = dec_valid & dec_ready & ~redirect_valid;
        push_s  = inflight_r & ~redirect_valid;
        // Occupancy after this cycle's pop counts the in-flight word as
        // already owning a slot, so a returning word always has room.
        // A pop implies count_r >= 1, so this never underflows.
        occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        if (!redirect_valid && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Fetch PC and in-flight tracking; redirect has priority over issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
        end else if (redirect_valid) begin
            pc_r          <= redirect_pc;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end else if (issue_s) begin
            pc_r          <= pc_r + PC_STEP;
            inflight_r    <= 1'b1;
            inflight_pc_r <= pc_r;
        end else begin
            pc_r          <= pc_r;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end
    end

    // Queue pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            rd_ptr_r <= pop_s  ? ~rd_ptr_r : rd_ptr_r;
            wr_ptr_r <= push_s ? ~wr_ptr_r : wr_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Queue storage; words are captured unmodified from the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_pc_r[0]  <= 32'h0000_0000;
            q_pc_r[1]  <= 32'h0000_0000;
            q_ins_r[0] <= 32'h0000_0000;
            q_ins_r[1] <= 32'h0000_0000;
        end else if (push_s) begin
            q_pc_r[wr_ptr_r]  <= inflight_pc_r;
            q_ins_r[wr_ptr_r] <= ins_in;
        end else begin
            q_pc_r[wr_ptr_r]  <= q_pc_r[wr_ptr_r];
            q_ins_r[wr_ptr_r] <= q_ins_r[wr_ptr_r];
        end
    end

    // Outputs are direct views of registered state.
    assign pc_out    = pc_r;
    assign base_out  = RESET_PC;
    assign dec_valid = (count_r != 2'd0);
    assign dec_ins   = q_ins_r[rd_ptr_r];
    assign dec_pc    = q_pc_r[rd_ptr_r];

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_out;
    logic [31:0] base_out;
    logic [31:0] ins_in = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [31:0] dec_ins;
    logic [31:0] dec_pc;

    int total = 0;
    int bad   = 0;

    // Reference model: visible queue of PCs, one in-flight PC, next fetch PC,
    // and the next PC decode is expected to accept.
    logic [31:0] mq[$];
    bit          m_inf = 0;
    logic [31:0] m_inf_pc = 32'h0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] exp_acc = 32'h0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd1)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .base_out(base_out),
        .ins_in(ins_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_ins(dec_ins), .dec_pc(dec_pc)
    );

    always #5 clk = ~clk;

    // Buffer contents: words 0..11 are nibble patterns, beyond that NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        logic [3:0] n;
        n = pc[3:0];
        if (pc < 32'd12) return {8{n}};
        return 32'h0000_0013;
    endfunction

    function automatic logic [31:0] head_pc();
        if (mq.size() != 0) return mq[0];
        return 32'h0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_inf = 0;
        m_pc = 32'h0;
        exp_acc = 32'h0;
    endtask

    // Advance one clock: update model, act as the buffer's registered read.
    task automatic tick();
        logic [31:0] presented;
        bit pop;
        int occ;
        presented = pc_out;
        pop = (mq.size() != 0) && dec_ready && !redirect_valid;
        if (redirect_valid) begin
            mq.delete();
            m_inf = 0;
            m_pc = redirect_pc;
            exp_acc = redirect_pc;
        end else begin
            occ = mq.size() + (m_inf ? 1 : 0) - (pop ? 1 : 0);
            if (pop) begin
                void'(mq.pop_front());
                exp_acc = exp_acc + 32'd1;
            end
            if (m_inf) mq.push_back(m_inf_pc);
            if (occ < 2) begin
                m_inf = 1;
                m_inf_pc = m_pc;
                m_pc = m_pc + 32'd1;
            end else begin
                m_inf = 0;
            end
        end
        @(posedge clk);
        #1;
        ins_in = mem_word(presented);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got %h exp %h", pc_out, 32'h0); end
        total++; if (base_out !== 32'h0) begin bad++; $display("FAIL reset_base_out got %h exp %h", base_out, 32'h0); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_dec_valid got %b exp 0", dec_valid); end
        total++; if (dec_ins !== 32'h0) begin bad++; $display("FAIL reset_dec_ins got %h exp %h", dec_ins, 32'h0); end
        total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL reset_dec_pc got %h exp %h", dec_pc, 32'h0); end
        model_reset();
    endtask

    task automatic test_stream();
        logic [31:0] tbl [3];
        tbl[0] = 32'h0000_0000; tbl[1] = 32'h1111_1111; tbl[2] = 32'h2222_2222;
        @(negedge clk);
        rst = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (pc_out !== m_pc) begin bad++; $display("FAIL stream_pc_out cyc %0d got %h exp %h", i, pc_out, m_pc); end
            total++; if (pc_out !== 32'(i)) begin bad++; $display("FAIL stream_pc_seq cyc %0d got %h exp %h", i, pc_out, 32'(i)); end
            total++; if (dec_valid !== (mq.size() != 0)) begin bad++; $display("FAIL stream_dec_valid cyc %0d got %b exp %b", i, dec_valid, mq.size() != 0); end
            if (i < 2) begin
                total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid cyc %0d got %b exp 0", i, dec_valid); end
            end
            if (i >= 2 && i < 5) begin
                total++; if (dec_pc !== 32'(i - 2) || dec_ins !== tbl[i-2]) begin
                    bad++; $display("FAIL stream_head cyc %0d got %h/%h exp %h/%h", i, dec_pc, dec_ins, 32'(i - 2), tbl[i-2]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] frozen;
        frozen = 32'h0;
        for (int i = 0; i < 14; i++) begin
            dec_ready = !(i >= 2 && i < 7);
            if (i == 5) frozen = m_pc;
            if (i == 6) begin
                total++; if (pc_out !== frozen) begin bad++; $display("FAIL bp_frozen got %h exp %h", pc_out, frozen); end
                total++; if (mq.size() != 2 || dec_valid !== 1'b1) begin bad++; $display("FAIL bp_saturate got valid=%b exp 1 (model depth %0d)", dec_valid, mq.size()); end
            end
            total++; if (pc_out !== m_pc) begin bad++; $display("FAIL bp_pc_out cyc %0d got %h exp %h", i, pc_out, m_pc); end
            total++; if (dec_valid !== (mq.size() != 0)) begin bad++; $display("FAIL bp_dec_valid cyc %0d got %b exp %b", i, dec_valid, mq.size() != 0); end
            if (dec_valid && dec_ready) begin
                total++; if (dec_pc !== exp_acc || dec_ins !== mem_word(exp_acc)) begin
                    bad++; $display("FAIL bp_accept cyc %0d got %h/%h exp %h/%h", i, dec_pc, dec_ins, exp_acc, mem_word(exp_acc));
                end
            end
            tick();
        end
        dec_ready = 1'b1;
    endtask

    task automatic test_redirect();
        int accepted;
        accepted = 0;
        dec_ready = 1'b1;
        tick();
        // Head valid, ready high, and a word returning: all must be dropped.
        redirect_valid = 1'b1;
        redirect_pc = 32'd5;
        tick();
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_drop got %b exp 0", dec_valid); end
        total++; if (pc_out !== 32'd5) begin bad++; $display("FAIL redir_pc_out got %h exp %h", pc_out, 32'd5); end
        for (int i = 0; i < 6; i++) begin
            if (i < 2) begin
                total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble cyc %0d got %b exp 0", i, dec_valid); end
            end
            total++; if (dec_valid !== (mq.size() != 0) || (dec_valid && dec_pc !== head_pc())) begin
                bad++; $display("FAIL redir_model cyc %0d got %b/%h exp %b/%h", i, dec_valid, dec_pc, mq.size() != 0, head_pc());
            end
            if (dec_valid && accepted < 2) begin
                total++; if (dec_pc !== 32'(5 + accepted) || dec_ins !== {8{4'(5 + accepted)}}) begin
                    bad++; $display("FAIL redir_target got %h/%h exp %h/%h", dec_pc, dec_ins, 32'(5 + accepted), {8{4'(5 + accepted)}});
                end
                accepted++;
            end
            tick();
        end
        total++; if (accepted != 2) begin bad++; $display("FAIL redir_count got %0d exp 2", accepted); end
    endtask

    task automatic test_nop();
        bit seen;
        seen = 0;
        redirect_valid = 1'b1;
        redirect_pc = 32'd10;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (dec_valid && dec_pc === 32'd12) begin
                seen = 1;
                total++; if (dec_ins !== 32'h0000_0013) begin bad++; $display("FAIL nop_ins got %h exp %h", dec_ins, 32'h13); end
            end
            total++; if (dec_valid && dec_pc !== head_pc()) begin bad++; $display("FAIL nop_head got %h exp %h", dec_pc, head_pc()); end
            tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL nop_seen got 0 exp 1"); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 15));
            end
            total++; if (pc_out !== m_pc) begin bad++; $display("FAIL rand_pc_out cyc %0d got %h exp %h", i, pc_out, m_pc); end
            total++; if (dec_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rand_dec_valid cyc %0d got %b exp %b", i, dec_valid, mq.size() != 0); end
            if (dec_valid) begin
                total++; if (dec_pc !== head_pc() || dec_ins !== mem_word(head_pc())) begin
                    bad++; $display("FAIL rand_head cyc %0d got %h/%h exp %h/%h", i, dec_pc, dec_ins, head_pc(), mem_word(head_pc()));
                end
            end
            if (dec_valid && dec_ready && !redirect_valid) begin
                total++; if (dec_pc !== exp_acc) begin bad++; $display("FAIL rand_contig cyc %0d got %h exp %h", i, dec_pc, exp_acc); end
            end
            tick();
        end
        dec_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL async_dec_valid got %b exp 0", dec_valid); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL async_pc_out got %h exp %h", pc_out, 32'h0); end
        total++; if (dec_pc !== 32'h0 || dec_ins !== 32'h0) begin bad++; $display("FAIL async_head got %h/%h exp 0/0", dec_pc, dec_ins); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (pc_out !== m_pc) begin bad++; $display("FAIL async_pc cyc %0d got %h exp %h", i, pc_out, m_pc); end
            total++; if (dec_valid !== (mq.size() != 0)) begin bad++; $display("FAIL async_valid cyc %0d got %b exp %b", i, dec_valid, mq.size() != 0); end
            if (dec_valid) begin
                total++; if (dec_pc !== exp_acc || dec_ins !== mem_word(exp_acc)) begin
                    bad++; $display("FAIL async_restart cyc %0d got %h/%h exp %h/%h", i, dec_pc, dec_ins, exp_acc, mem_word(exp_acc));
                end
            end
            tick();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_nop();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
